// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - iterative multiply/divide unit with architectural HI/LO registers
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               signed_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Magnitudes are unsigned WIDTH-bit values, so the most negative input maps onto itself
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && a[WIDTH-1];
        b_neg     = signed_op && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        mul_next = {add_sum, acc_q[WIDTH-1:1]};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd_q};
        // diff[WIDTH] set means the trial subtraction borrowed: restore and shift in a 0
        div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        OP_MULT, OP_MULTU: begin
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            opnd_d    = a_mag;
                            is_div_d  = 1'b0;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            cnt_d     = '0;
                            state_d   = S_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            opnd_d    = b_mag;
                            a_raw_d   = a;
                            is_div_d  = 1'b1;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = (b == '0);
                            cnt_d     = '0;
                            state_d   = S_CALC;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d  = a_raw_q;
                    lo_d  = {WIDTH{1'b1}};
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - directed self-checking bench for muldiv_hilo_unit
module tb_muldiv_hilo_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the sampling edge E0
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        a     = 32'hA5A5_A5A5;
        b     = 32'h5A5A_5A5A;
    endtask

    task automatic wait_done(input int inject, output int edges, output bit busy_seen, output bit hold_ok);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        edges = 1;
        busy_seen = busy;
        hold_ok = 1'b1;
        while (!done && edges < 100) begin
            if (busy && (hi !== h0 || lo !== l0)) hold_ok = 1'b0;
            @(negedge clk);
            edges++;
            if (inject != 0) begin
                if (edges == inject) begin
                    start = 1'b1;
                    op    = OP_DIVU;
                    a     = 32'd9;
                    b     = 32'd3;
                end else begin
                    start = 1'b0;
                end
            end
            if (busy) busy_seen = 1'b1;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int inject, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_dz, input int exp_edges);
        int edges;
        bit busy_seen, hold_ok;
        issue(o, x, y);
        wait_done(inject, edges, busy_seen, hold_ok);
        check_eq({tag, "/latency"}, 64'(edges), 64'(exp_edges));
        check_eq({tag, "/hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, "/lo"}, 64'(lo), 64'(exp_lo));
        check_eq({tag, "/dbz"}, 64'(div_by_zero), 64'(exp_dz));
        check_eq({tag, "/busy_at_done"}, 64'(busy), 64'h0);
        check_eq({tag, "/busy_seen"}, 64'(busy_seen), 64'(exp_edges > 1));
        if (exp_edges > 1) check_eq({tag, "/hold"}, 64'(hold_ok), 64'h1);
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst/busy", 64'(busy), 64'h0);
        check_eq("rst/done", 64'(done), 64'h0);
        check_eq("rst/dbz", 64'(div_by_zero), 64'h0);
        check_eq("rst/hi", 64'(hi), 64'h0);
        check_eq("rst/lo", 64'(lo), 64'h0);

        run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'h0);

        run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000, 1'b0, 34);
        run("divu_7_2", OP_DIVU, 32'd7, 32'd2, 0, 32'd1, 32'd3, 1'b0, 34);
        run("divu_zero", OP_DIVU, 32'd7, 32'd0, 0, 32'd7, 32'hFFFF_FFFF, 1'b1, 34);
        run("div_neg_zero", OP_DIV, 32'hFFFF_FFF0, 32'd0, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 34);
        run("mthi", OP_MTHI, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1);
        run("mtlo", OP_MTLO, 32'hCAFE_BABE, 32'd0, 0, 32'h1234_5678, 32'hCAFE_BABE, 1'b0, 1);

        @(negedge clk);
        start = 1'b1;
        op    = 3'b110;
        a     = 32'h1111_1111;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
            if (done || busy) pulses++;
        end
        check_eq("reserved/ignored", 64'(pulses), 64'h0);
        check_eq("reserved/hi", 64'(hi), 64'h1234_5678);

        run("multu_busy_start", OP_MULTU, 32'd3, 32'd4, 10, 32'd0, 32'd12, 1'b0, 34);
        run("back_to_back", OP_MULTU, 32'd6, 32'd7, 0, 32'd0, 32'd42, 1'b0, 34);

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst/busy", 64'(busy), 64'h0);
        check_eq("midrst/done", 64'(done), 64'h0);
        check_eq("midrst/hi", 64'(hi), 64'h0);
        check_eq("midrst/lo", 64'(lo), 64'h0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_eq("midrst/no_done", 64'(pulses), 64'h0);
        run("after_rst", OP_MULTU, 32'd5, 32'd5, 0, 32'd0, 32'd25, 1'b0, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Parametrised in operand width; successor to the combinational mult + hilo pair in the single-cycle datapath.
- Supports signed and unsigned multiply, signed and unsigned divide, and direct HI/LO writes.
- Sits beside the ALU: operands come from register-file read ports; the HI/LO outputs feed the HI/LO select mux in front of the register-file write-data path.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- b  input  WIDTH  rt operand (multiplier / divisor).
- busy  output  1  operation in progress; high in CALC and FIX.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  pulses together with done when DIV/DIVU had b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, rst high at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset has priority over everything, including mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MTHI/MTLO: at edge E0 write a into hi (or lo); done=1 next cycle; busy stays 0; stay IDLE.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU: at E0 latch the operand magnitudes.
  - Signed ops: magnitude=two's-complement absolute value, taken as a WIDTH-bit unsigned value so that -2^(WIDTH-1) maps to 2^(WIDTH-1).
  - Record the result sign(s), clear the counter, go to CALC, busy=1.
- Reserved op with start=1: ignored; no state change, no done.
- CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, on 2*WIDTH-bit internal accumulators. After the WIDTH-th step (edge E_WIDTH) go to FIX.
- FIX (edge E_WIDTH+1): apply the sign fixup and write hi/lo in the same edge; done=1 in the following cycle; busy=0; return to IDLE.
  - Multiply: {hi,lo} = full 2*WIDTH-bit product; negated if the operand signs differ (signed only).
  - Divide: lo=quotient, hi=remainder. Quotient is negated if the signs differ. Remainder takes the dividend's sign. Truncation is toward zero.
  - Signed overflow (-2^(WIDTH-1) / -1): lo=0x80..0, hi=0.
  - Divide by zero: latency unchanged; hi=a (unmodified dividend), lo=all ones; div_by_zero=1 with done.
- Latency: start sampled at E0 → done high in the cycle after edge E0+WIDTH+1 (WIDTH+2 edges). With WIDTH=32, done is visible 34 cycles after the start edge.
- hi/lo hold their previous values for the entire CALC period and change only at the FIX edge. Reads during busy return the old values.
- start while busy=1: ignored; no queueing.
- start in the same cycle done=1: accepted (state is IDLE).
- done and div_by_zero are single-cycle pulses and are never high while busy=1.
- Operand inputs a, b and op may change freely after E0.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → 34 cycles later done=1, hi=0xFFFFFFFE, lo=0x00000001, busy low that cycle.
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=7, b=0 → done and div_by_zero both high, hi=7, lo=0xFFFFFFFF.
- MTHI a=0x12345678 → done next cycle, hi=0x12345678, busy never high. Then MTLO a=0xCAFEBABE → lo updated, hi unchanged.
- MULTU 3×4 started; start pulsed with DIVU 9/3 at cycle 10 → ignored, result hi=0, lo=12. Back-to-back start in the done cycle → second op completes 34 cycles later.
- rst asserted at cycle 15 of a MULT → next cycle busy=0, done=0, hi=lo=0. No done pulse follows; a new op completes normally.
